// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the two ALU clients plus the shared ALU connection.
// The slave modport is the arbiter's view; the master modport is the clients' and ALU's view.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic             rsp0_zero;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic             rsp1_zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_zero,
        output rsp1_valid, rsp1_result, rsp1_zero,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_zero,
        input  rsp1_valid, rsp1_result, rsp1_zero,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared combinational ALU.
// Each granted op is computed in its grant cycle and parked in that port's response slot.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    alu_arbiter_if.slave  bus
);
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp0_result;
    logic [WIDTH-1:0] r_rsp1_result;
    logic             r_rsp0_zero;
    logic             r_rsp1_zero;
    logic             r_last_grant;

    logic             w_elig0;
    logic             w_elig1;
    logic             w_grant0;
    logic             w_grant1;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [2:0]       w_alu_control;

    // A slot draining this cycle can take a new result on the same edge.
    assign w_elig0  = bus.req0_valid && (!r_rsp0_valid || bus.rsp0_ready);
    assign w_elig1  = bus.req1_valid && (!r_rsp1_valid || bus.rsp1_ready);
    assign w_grant0 = w_elig0 && (!w_elig1 || r_last_grant);
    assign w_grant1 = w_elig1 && (!w_elig0 || !r_last_grant);

    always_comb begin
        w_alu_a       = '0;
        w_alu_b       = '0;
        w_alu_control = 3'b000;
        if (w_grant0) begin
            w_alu_a       = bus.req0_a;
            w_alu_b       = bus.req0_b;
            w_alu_control = bus.req0_op;
        end else if (w_grant1) begin
            w_alu_a       = bus.req1_a;
            w_alu_b       = bus.req1_b;
            w_alu_control = bus.req1_op;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp1_result <= '0;
            r_rsp0_zero   <= 1'b0;
            r_rsp1_zero   <= 1'b0;
            r_last_grant  <= 1'b1;
        end else begin
            if (w_grant0) begin
                r_rsp0_valid  <= 1'b1;
                r_rsp0_result <= bus.alu_result;
                r_rsp0_zero   <= bus.alu_zero;
                r_last_grant  <= 1'b0;
            end else if (r_rsp0_valid && bus.rsp0_ready) begin
                r_rsp0_valid <= 1'b0;
            end

            if (w_grant1) begin
                r_rsp1_valid  <= 1'b1;
                r_rsp1_result <= bus.alu_result;
                r_rsp1_zero   <= bus.alu_zero;
                r_last_grant  <= 1'b1;
            end else if (r_rsp1_valid && bus.rsp1_ready) begin
                r_rsp1_valid <= 1'b0;
            end
        end
    end

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.alu_a       = w_alu_a;
    assign bus.alu_b       = w_alu_b;
    assign bus.alu_control = w_alu_control;
    assign bus.rsp0_valid  = r_rsp0_valid;
    assign bus.rsp1_valid  = r_rsp1_valid;
    assign bus.rsp0_result = r_rsp0_result;
    assign bus.rsp1_result = r_rsp1_result;
    assign bus.rsp0_zero   = r_rsp0_zero;
    assign bus.rsp1_zero   = r_rsp1_zero;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter sharing the single 32-bit ALU between two requesters (e.g. main datapath and a future address/branch unit). Each port presents an operation with a valid/ready handshake. The arbiter drives the shared ALU combinationally for the granted port and registers the result into that port's response slot, held until accepted. One ALU operation per cycle total; one-cycle latency from grant to response.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  port n has an operation pending.
- req0_ready / req1_ready  out  1  port n granted this cycle (combinational).
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  3  ALU control code.
- rsp0_valid / rsp1_valid  out  1  response slot n holds a result.
- rsp0_ready / rsp1_ready  in  1  consumer n accepts response.
- rsp0_result / rsp1_result  out  WIDTH  registered ALU result.
- rsp0_zero / rsp1_zero  out  1  registered ALU zero flag.
- alu_a, alu_b  out  WIDTH  operands to shared ALU.
- alu_control  out  3  control to shared ALU.
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_control).
- alu_zero  in  1  ALU zero flag.

## Operation
- ALU codes passed through unchanged: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (unsigned compare), 100 NOR; any other code yields result 0, zero 1. Arbiter does not decode or check op.
- Eligibility: port n eligible when reqn_valid && (!rspn_valid || rspn_ready); a slot being drained this cycle may be refilled in the same cycle.
- Grant: if one port eligible, grant it. If both eligible, grant the port not recorded in last_grant. If none, no grant.
- reqn_ready = grant to n. Handshake completes when reqn_valid && reqn_ready. At most one of req0_ready/req1_ready high in any cycle.
- ALU drive: granted port's a/b/op on alu_a/alu_b/alu_control. No grant: all driven 0 (AND of zeros).
- On grant edge: rspn_result <= alu_result, rspn_zero <= alu_zero, rspn_valid <= 1, last_grant <= n.
- Slot drain: rspn_valid && rspn_ready with no new grant to n -> rspn_valid <= 0; result/zero hold last value.
- Simultaneous drain and refill of same slot: rspn_valid stays 1, new result loaded.
- Backpressure on one port never blocks the other port.
- Requesters must hold valid, a, b, op stable until ready; arbiter does not latch requests.
- last_grant is a single bit register.

## Timing
- Reset values: rsp0_valid=0, rsp1_valid=0, rsp*_result=0, rsp*_zero=0, last_grant=1 (port 0 wins first tie). req*_ready, alu_* follow combinational rules (0 when req*_valid low).
- Latency: request granted in cycle T -> rspn_valid high and result visible in cycle T+1.
- Throughput: one operation per cycle aggregate; single port sustains one per cycle while its rsp_ready is held high.
- Under continuous contention with both rsp_ready high: grants alternate 0,1,0,1.
- Reset mid-operation: any granted-but-unregistered op and all pending responses discarded; rsp_valid low cycle after reset; requester must re-issue.
- No combinational path from rsp_ready to rsp outputs; combinational paths exist req_valid/rsp_ready -> req_ready and -> alu_*.

## Test plan
- Single op: after reset, req0 ADD a=5 b=3 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_result=8, rsp0_zero=0.
- Zero flag / unknown op: req1 SUB a=7 b=7 -> rsp1_result=0, rsp1_zero=1; req1 op 011 a=9 b=1 -> rsp1_result=0, rsp1_zero=1.
- Tie after reset: both valid (req0 OR 0xF0|0x0F, req1 SLT 2<3) -> port 0 granted cycle 0 (rsp0_result=0xFF), port 1 cycle 1 (rsp1_result=1); continued contention alternates.
- Backpressure: rsp0_ready=0 with rsp0_valid=1 and req0_valid=1 -> req0_ready=0 every cycle, rsp0_result held; req1 ops granted each cycle; raising rsp0_ready regrants port 0 same cycle.
- Drain+refill: rsp0_valid=1, rsp0_ready=1, req0 AND 0xC & 0xA -> next cycle rsp0_valid=1, rsp0_result=0x8, no bubble.
- Reset mid-stream: assert reset while rsp0_valid=1 and req1 granted -> next cycle both rsp_valid=0, results 0, port 0 wins next tie.
